if_id_stage_reg: RTL and testbench



---
 rtl/if_id_stage_reg.sv | 157 +++++++++++++++
 tb/tb_if_id_stage_reg.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage_reg.sv
// ============================================================================
// Module   : if_id_stage_reg
// Purpose  : IF/ID pipeline register with a one-entry skid buffer. Honours
//            decode stall and fetch flush requests. Presents NOP bubbles to
//            decode when the slot is empty.
// Options  : IFID_PERF_CNT_EN enables the stall/flush performance counters.
//            When it is undefined, both counter ports read zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_stage_reg #(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] NOP_INS = 'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [DATA_W-1:0] fetch_ins,
  input  logic [DATA_W-1:0] fetch_pc_inc,
  output logic              fetch_ready,
  input  logic              stall_decode,
  input  logic              flush_fetch,
  output logic [DATA_W-1:0] id_ins,
  output logic [DATA_W-1:0] id_pc_inc,
  output logic              id_valid,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ins_q, ins_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] skid_ins_q, skid_ins_d;
  logic [DATA_W-1:0] skid_pc_q, skid_pc_d;
  logic              accept;

  // Ready is a function of state only, so fetch can never see a loop through fetch_valid.
  assign fetch_ready = (state_q != ST_SKID) & ~rst;
  assign accept      = fetch_valid & fetch_ready;
  assign id_valid    = (state_q != ST_EMPTY);
  assign id_ins      = ins_q;
  assign id_pc_inc   = pc_q;

  // Next state and data. Flush beats stall. The PC field keeps its old value on a bubble.
  always_comb begin
    state_d    = state_q;
    ins_d      = ins_q;
    pc_d       = pc_q;
    skid_ins_d = skid_ins_q;
    skid_pc_d  = skid_pc_q;
    if (flush_fetch) begin
      state_d    = ST_EMPTY;
      ins_d      = NOP_INS;
      skid_ins_d = '0;
      skid_pc_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          // A stall against a bubble is meaningless, so it is ignored here.
          if (accept) begin
            ins_d   = fetch_ins;
            pc_d    = fetch_pc_inc;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (!stall_decode) begin
            if (accept) begin
              ins_d = fetch_ins;
              pc_d  = fetch_pc_inc;
            end else begin
              ins_d   = NOP_INS;
              state_d = ST_EMPTY;
            end
          end else if (accept) begin
            // This is the beat already in flight when the stall arrived. Park it behind the held instruction.
            skid_ins_d = fetch_ins;
            skid_pc_d  = fetch_pc_inc;
            state_d    = ST_SKID;
          end
        end
        ST_SKID: begin
          if (!stall_decode) begin
            ins_d      = skid_ins_q;
            pc_d       = skid_pc_q;
            skid_ins_d = '0;
            skid_pc_d  = '0;
            state_d    = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          ins_d   = NOP_INS;
        end
      endcase
    end
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      ins_q      <= NOP_INS;
      pc_q       <= '0;
      skid_ins_q <= '0;
      skid_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      ins_q      <= ins_d;
      pc_q       <= pc_d;
      skid_ins_q <= skid_ins_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters. One counts stalled cycles that hold a real instruction; the other counts flush cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_decode && id_valid && !flush_fetch && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_fetch && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Counter registers; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = 16'h0000;
  assign flush_count  = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage_reg.sv
// ============================================================================
// Module   : tb_if_id_stage_reg
// Purpose  : Self-checking bench for if_id_stage_reg. A queue-based model of
//            in-flight instructions supplies every expected value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_stage_reg;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [15:0] fetch_ins;
  logic [15:0] fetch_pc_inc;
  logic        fetch_ready;
  logic        stall_decode;
  logic        flush_fetch;
  logic [15:0] id_ins;
  logic [15:0] id_pc_inc;
  logic        id_valid;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Model: the front of the queue is what decode sees. At most two entries are held.
  logic [15:0] m_ins[$];
  logic [15:0] m_pc[$];
  logic [15:0] m_last_pc;
  logic [15:0] m_stall;
  logic [15:0] m_flush;

  if_id_stage_reg #(.DATA_W(16), .NOP_INS(16'h0800)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_valid  (fetch_valid),
    .fetch_ins    (fetch_ins),
    .fetch_pc_inc (fetch_pc_inc),
    .fetch_ready  (fetch_ready),
    .stall_decode (stall_decode),
    .flush_fetch  (flush_fetch),
    .id_ins       (id_ins),
    .id_pc_inc    (id_pc_inc),
    .id_valid     (id_valid),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("id_valid", {15'd0, id_valid}, {15'd0, (m_ins.size() > 0)});
    check_eq("id_ins", id_ins, (m_ins.size() > 0) ? m_ins[0] : 16'h0800);
    check_eq("id_pc_inc", id_pc_inc, m_last_pc);
`ifdef IFID_PERF_CNT_EN
    check_eq("stall_cycles", stall_cycles, m_stall);
    check_eq("flush_count", flush_count, m_flush);
`else
    check_eq("stall_cycles", stall_cycles, 16'h0000);
    check_eq("flush_count", flush_count, 16'h0000);
`endif
  endtask

  // Drive one cycle of inputs, check ready before the edge, update the model, then check the outputs.
  task automatic step(input logic r, input logic fv, input logic [15:0] ins,
                      input logic [15:0] pc, input logic st, input logic fl);
    logic acc;
    logic exp_ready;
    @(negedge clk);
    rst = r; fetch_valid = fv; fetch_ins = ins; fetch_pc_inc = pc;
    stall_decode = st; flush_fetch = fl;
    #1;
    exp_ready = !r && (m_ins.size() < 2);
    check_eq("fetch_ready", {15'd0, fetch_ready}, {15'd0, exp_ready});
    @(posedge clk);
    if (r) begin
      m_ins.delete(); m_pc.delete();
      m_last_pc = 16'h0000; m_stall = 16'h0000; m_flush = 16'h0000;
    end else begin
      acc = fv && exp_ready;
      if (st && (m_ins.size() > 0) && !fl && m_stall != 16'hFFFF) m_stall++;
      if (fl && m_flush != 16'hFFFF) m_flush++;
      if (fl) begin
        m_ins.delete(); m_pc.delete();
      end else begin
        if ((!st || m_ins.size() == 0) && m_ins.size() > 0) begin
          void'(m_ins.pop_front()); void'(m_pc.pop_front());
        end
        if (acc) begin
          m_ins.push_back(ins); m_pc.push_back(pc);
        end
      end
      if (m_pc.size() > 0) m_last_pc = m_pc[0];
    end
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_ins = '0; fetch_pc_inc = '0;
    stall_decode = 1'b0; flush_fetch = 1'b0;
    m_last_pc = 16'h0000; m_stall = 16'h0000; m_flush = 16'h0000;

    step(1, 0, 16'h0000, 16'h0000, 0, 0);
    step(1, 1, 16'h1111, 16'h2222, 1, 0);

    // Three back-to-back fetches followed by a bubble.
    step(0, 1, 16'h4001, 16'h0002, 0, 0);
    check_eq("tp1_ins1", id_ins, 16'h4001);
    step(0, 1, 16'h4002, 16'h0004, 0, 0);
    check_eq("tp1_ins2", id_ins, 16'h4002);
    step(0, 1, 16'h4003, 16'h0006, 0, 0);
    check_eq("tp1_ins3", id_ins, 16'h4003);
    step(0, 0, 16'h0000, 16'h0000, 0, 0);
    check_eq("tp1_bubble", id_ins, 16'h0800);

    // A stall with an in-flight beat goes to the skid buffer.
    step(0, 1, 16'hA000, 16'h0010, 0, 0);
    step(0, 1, 16'hA001, 16'h0012, 1, 0);
    check_eq("tp2_hold1", id_ins, 16'hA000);
    step(0, 1, 16'hA0FF, 16'h00FF, 1, 0);
    check_eq("tp2_hold2", id_ins, 16'hA000);
    step(0, 1, 16'hA0FE, 16'h00FE, 1, 0);
    check_eq("tp2_hold3", id_ins, 16'hA000);
    step(0, 0, 16'h0000, 16'h0000, 0, 0);
    check_eq("tp2_skid_out", id_ins, 16'hA001);
    step(0, 1, 16'hA003, 16'h0016, 0, 0);
    check_eq("tp2_next", id_ins, 16'hA003);

    // Flush while the skid buffer is full; the same-cycle fetch is dropped.
    step(0, 1, 16'hB000, 16'h0020, 0, 0);
    step(0, 1, 16'hB001, 16'h0022, 1, 0);
    step(0, 1, 16'hB002, 16'h0024, 1, 1);
    check_eq("tp3_flush_ins", id_ins, 16'h0800);
    check_eq("tp3_flush_valid", {15'd0, id_valid}, 16'h0000);

    // Reset while the skid buffer is full.
    step(0, 1, 16'hC000, 16'h0030, 0, 0);
    step(0, 1, 16'hC001, 16'h0032, 1, 0);
    step(1, 1, 16'hC002, 16'h0034, 1, 0);
    check_eq("tp4_rst_pc", id_pc_inc, 16'h0000);

    // A stall raised while empty is ignored.
    step(0, 1, 16'h6123, 16'h0040, 1, 0);
    check_eq("tp5_load", id_ins, 16'h6123);

    // Five valid stall cycles, then two flushes.
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0000, 16'h0000, 1, 0);
    step(0, 0, 16'h0000, 16'h0000, 0, 1);
    step(0, 0, 16'h0000, 16'h0000, 0, 1);
`ifdef IFID_PERF_CNT_EN
    check_eq("tp6_stall", stall_cycles, 16'd5);
    check_eq("tp6_flush", flush_count, 16'd2);
`else
    check_eq("tp6_stall", stall_cycles, 16'd0);
    check_eq("tp6_flush", flush_count, 16'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 2) != 0),
           16'($urandom), 16'($urandom),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 11) == 0));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

`default_nettype wire
